vfu_result_wr_arbiter: RTL

// - Lane-side responder for the ALU and MFPU result write interfaces (req/id/addr/wdata/be, gnt).
// - Buffers each unit's results in its own FIFO.
// - Arbitrates between the FIFOs round-robin onto a single VRF write port with valid/ready.
// - Lets both units retire results back-to-back while the VRF port stalls.

---
 rtl/vfu_result_wr_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/vfu_result_wr_arbiter.sv
// vfu_result_wr_arbiter: per-unit result FIFOs (ALU, MFPU) arbitrated round-robin onto one VRF write port.
// Optional WR_ARB_PUSH_ON_POP_EN lets a full FIFO grant in the cycle it is popped.
module vfu_result_wr_arbiter #(
  parameter int unsigned NrLanes    = 4,
  parameter int unsigned VaddrWidth = 10,
  parameter int unsigned BufDepth   = 2,
  parameter int unsigned DataWidth  = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alu_result_req_i,
  input  logic [2:0]             alu_result_id_i,
  input  logic [VaddrWidth-1:0]  alu_result_addr_i,
  input  logic [DataWidth-1:0]   alu_result_wdata_i,
  input  logic [DataWidth/8-1:0] alu_result_be_i,
  output logic                   alu_result_gnt_o,
  input  logic                   mfpu_result_req_i,
  input  logic [2:0]             mfpu_result_id_i,
  input  logic [VaddrWidth-1:0]  mfpu_result_addr_i,
  input  logic [DataWidth-1:0]   mfpu_result_wdata_i,
  input  logic [DataWidth/8-1:0] mfpu_result_be_i,
  output logic                   mfpu_result_gnt_o,
  output logic                   vrf_wr_req_o,
  output logic [2:0]             vrf_wr_id_o,
  output logic [VaddrWidth-1:0]  vrf_wr_addr_o,
  output logic [DataWidth-1:0]   vrf_wr_wdata_o,
  output logic [DataWidth/8-1:0] vrf_wr_be_o,
  output logic                   vrf_wr_src_o,
  input  logic                   vrf_wr_ready_i
);
  localparam int unsigned AW = $clog2(BufDepth);
  localparam int unsigned EW = 3 + VaddrWidth + DataWidth + DataWidth / 8;
  logic [1:0]         req, gnt, pop, empty, full;
  logic [1:0][EW-1:0] din, head;
  logic               win, fire, ptr_q, lock_q, lock_src_q, unused_cfg;
  assign unused_cfg = ^32'(NrLanes);
  assign req = {mfpu_result_req_i, alu_result_req_i};
  assign din[0] = {alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i};
  assign din[1] = {mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i};
  assign vrf_wr_req_o = ~&empty;
  // A stalled winner is latched so a late arrival in the other FIFO cannot steal the port.
  assign win = lock_q ? lock_src_q : empty[0] ? 1'b1 : empty[1] ? 1'b0 : ptr_q;
  assign fire = vrf_wr_req_o & vrf_wr_ready_i;
  assign pop = {fire & win, fire & ~win};
`ifdef WR_ARB_PUSH_ON_POP_EN
  assign gnt = req & (~full | pop);
`else
  assign gnt = req & ~full;
`endif
  assign alu_result_gnt_o = gnt[0];
  assign mfpu_result_gnt_o = gnt[1];
  assign {vrf_wr_id_o, vrf_wr_addr_o, vrf_wr_wdata_o, vrf_wr_be_o} = vrf_wr_req_o ? head[win] : '0;
  assign vrf_wr_src_o = vrf_wr_req_o & win;
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [EW-1:0] mem_q [BufDepth];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    assign empty[g] = cnt_q == '0;
    assign full[g] = cnt_q == (AW+1)'(BufDepth);
    assign head[g] = mem_q[rd_q];
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        rd_q <= '0;
        wr_q <= '0;
        cnt_q <= '0;
      end else begin
        if (gnt[g]) wr_q <= wr_q + 1'b1;
        if (pop[g]) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + (AW+1)'(gnt[g]) - (AW+1)'(pop[g]);
      end
    always_ff @(posedge clk_i)
      if (gnt[g]) mem_q[wr_q] <= din[g];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ptr_q <= 1'b0;
      lock_q <= 1'b0;
      lock_src_q <= 1'b0;
    end else begin
      lock_q <= vrf_wr_req_o & ~vrf_wr_ready_i;
      lock_src_q <= win;
      if (fire & ~|empty) ptr_q <= ~win;
    end
`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(|(gnt & full & ~pop)));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(|(pop & empty)));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> vrf_wr_req_o && vrf_wr_src_o == lock_src_q &&
    $stable({vrf_wr_id_o, vrf_wr_addr_o, vrf_wr_wdata_o, vrf_wr_be_o}));
`endif
endmodule
